// File: rtl/remote_stp_pkg.sv
// Shared types and constants for the remote-STP JTAG shift engine.
package remote_stp_pkg;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;
    localparam int IDX_W    = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_RESP
    } t_jtag_shift_state;

    typedef struct packed {
        logic [31:0] cmds_done;
        logic [31:0] bits_shifted;
    } t_remotestp_status;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_bits);
        return (int'(len) > max_bits) ? LEN_W'(max_bits) : len;
    endfunction

endpackage

// File: rtl/remote_stp_jtag_shifter_if.sv
// Command/response handshake bundle between the CSR front end and the JTAG shift engine.
interface remote_stp_jtag_shifter_if;
    import remote_stp_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len;
    logic [MAX_BITS-1:0] cmd_tms;
    logic [MAX_BITS-1:0] cmd_tdi;
    logic                cmd_parity;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [MAX_BITS-1:0] rsp_tdo;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_parity, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_parity, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo, rsp_err
    );

endinterface

// File: rtl/remote_stp_tck_div.sv
// TCK half-period timer: strobes lo_done/hi_done on the last clk cycle of each TCK phase.
module remote_stp_tck_div #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic phase_hi,
    output logic lo_done,
    output logic hi_done
);
    import remote_stp_pkg::*;

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_end;

    assign at_end  = (cnt_q == CNT_W'(TCK_DIV - 1));
    assign lo_done = run && !phase_hi && at_end;
    assign hi_done = run &&  phase_hi && at_end;

    // Counter restarts at every phase boundary so each phase lasts exactly TCK_DIV cycles.
    always_comb begin
        cnt_d = '0;
        if (run && !at_end) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/remote_stp_jtag_shifter.sv
// Command-driven JTAG shift engine: divided TCK, LSB-first TMS/TDI shifting, TDO capture.
// Optional command-parity checking is built when REMOTE_STP_PARITY_EN is defined.
module remote_stp_jtag_shifter #(
    parameter int TCK_DIV  = 2,
    parameter int MAX_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    remote_stp_jtag_shifter_if.slave   bus,
    output logic                       o_sr2pr_tck,
    output logic                       o_sr2pr_tckena,
    output logic                       o_sr2pr_tms,
    output logic                       o_sr2pr_tdi,
    input  logic                       i_pr2sr_tdo,
    output logic [63:0]                remotestp_status,
    output logic                       remotestp_parity_err
);
    import remote_stp_pkg::*;

    t_jtag_shift_state   state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d, len_clamp;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MAX_BITS-1:0] tms_vec_q, tms_vec_d, tdi_vec_q, tdi_vec_d, tdo_q, tdo_d;
    logic                tck_q, tck_d, tckena_q, tckena_d, tms_q, tms_d, tdi_q, tdi_d;
    logic                ready_q, ready_d;
    logic [31:0]         cmds_q, cmds_d, bits_q, bits_d;
    logic                accept, lo_done, hi_done, bad_parity;
    t_remotestp_status   status;

    assign len_clamp = clamp_len(bus.cmd_len, MAX_BITS);
    assign accept    = ready_q && bus.cmd_valid;

`ifdef REMOTE_STP_PARITY_EN
    logic err_q, err_d, perr_q, perr_d;

    assign bad_parity = bus.cmd_parity != (^{bus.cmd_len, bus.cmd_tms, bus.cmd_tdi});

    always_comb begin
        err_d  = err_q;
        perr_d = perr_q;
        if (accept) begin
            err_d  = bad_parity;
            perr_d = perr_q | bad_parity;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            perr_q <= perr_d;
        end
    end

    assign bus.rsp_err           = err_q;
    assign remotestp_parity_err  = perr_q;
`else
    assign bad_parity            = 1'b0;
    assign bus.rsp_err           = 1'b0;
    assign remotestp_parity_err  = 1'b0;
`endif

    remote_stp_tck_div #(.TCK_DIV(TCK_DIV)) u_tck_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)),
        .phase_hi (state_q == S_SHIFT_HI),
        .lo_done  (lo_done),
        .hi_done  (hi_done)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tms_vec_d = tms_vec_q;
        tdi_vec_d = tdi_vec_q;
        tdo_d     = tdo_q;
        tck_d     = tck_q;
        tckena_d  = tckena_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        cmds_d    = cmds_q;
        bits_d    = bits_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d     = len_clamp;
                    tms_vec_d = bus.cmd_tms;
                    tdi_vec_d = bus.cmd_tdi;
                    idx_d     = '0;
                    tdo_d     = '0;
                    if (bad_parity || (len_clamp == '0)) begin
                        state_d = S_RESP;
                    end else begin
                        tms_d    = bus.cmd_tms[0];
                        tdi_d    = bus.cmd_tdi[0];
                        tckena_d = 1'b1;
                        state_d  = S_SHIFT_LO;
                    end
                end
            end
            S_SHIFT_LO: begin
                if (lo_done) begin
                    tdo_d[idx_q] = i_pr2sr_tdo;
                    tck_d        = 1'b1;
                    state_d      = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (hi_done) begin
                    idx_d  = idx_q + 1'b1;
                    bits_d = bits_q + 32'd1;
                    tck_d  = 1'b0;
                    // TMS/TDI only move together with the falling TCK edge.
                    if ({1'b0, idx_q} == (len_q - 6'd1)) begin
                        tckena_d = 1'b0;
                        state_d  = S_RESP;
                    end else begin
                        tms_d   = tms_vec_q[idx_q + 1'b1];
                        tdi_d   = tdi_vec_q[idx_q + 1'b1];
                        state_d = S_SHIFT_LO;
                    end
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    cmds_d  = cmds_q + 32'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            tms_vec_q <= '0;
            tdi_vec_q <= '0;
            tdo_q     <= '0;
            tck_q     <= 1'b0;
            tckena_q  <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            ready_q   <= 1'b0;
            cmds_q    <= '0;
            bits_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tms_vec_q <= tms_vec_d;
            tdi_vec_q <= tdi_vec_d;
            tdo_q     <= tdo_d;
            tck_q     <= tck_d;
            tckena_q  <= tckena_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            ready_q   <= ready_d;
            cmds_q    <= cmds_d;
            bits_q    <= bits_d;
        end
    end

    assign bus.cmd_ready      = ready_q;
    assign bus.rsp_valid      = (state_q == S_RESP);
    assign bus.rsp_tdo        = tdo_q;
    assign o_sr2pr_tck        = tck_q;
    assign o_sr2pr_tckena     = tckena_q;
    assign o_sr2pr_tms        = tms_q;
    assign o_sr2pr_tdi        = tdi_q;
    assign status.cmds_done    = cmds_q;
    assign status.bits_shifted = bits_q;
    assign remotestp_status   = status;

endmodule
